mandel_cell_worker: RTL and testbench

- Mandelbrot escape-time compute engine.
- Pulls (idx, x0, y0) work items from an upstream ready/read queue (RTC side) and iterates z = z^2 + c in a recirculating pipeline.
- Writes each finished cell's iteration count into an internal iteration RAM addressed by idx.
- The video/readout side reads that RAM through a synchronous read port.

---
 rtl/mandel_cell_worker.sv | 193 +++++++++++++++++++
 tb/tb_mandel_cell_worker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_cell_worker.sv
// Mandelbrot escape-time worker: fetches (idx, x0, y0) cells, iterates z = z^2 + c in a
// recirculating ring and stores iteration counts in an internal RAM. Optional done port: CELL_WORKER_DONE_PORT_EN.
module mandel_cell_worker #(
  parameter int unsigned IDX_BITS   = 17,
  parameter int unsigned ITER_BITS  = 8,
  parameter int unsigned MAX_ITER   = 255,
  parameter int unsigned COORD_BITS = 64,
  parameter int unsigned FRAC_BITS  = 58,
  parameter int unsigned STAGES     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rtc_poll_ready,
  output logic                  rtc_read,
  input  logic [IDX_BITS-1:0]   idx_from_rtc,
  input  logic [COORD_BITS-1:0] x0_from_rtc,
  input  logic [COORD_BITS-1:0] y0_from_rtc,
  input  logic [IDX_BITS-1:0]   iter_idx_in,
  output logic [ITER_BITS-1:0]  iter_out
`ifdef CELL_WORKER_DONE_PORT_EN
  ,
  output logic                  done_valid,
  output logic [IDX_BITS-1:0]   done_idx,
  output logic [ITER_BITS-1:0]  done_iter,
  output logic                  done_escaped
`endif
);

  localparam int unsigned PROD_W    = 2 * COORD_BITS;
  localparam int unsigned RAM_DEPTH = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0]  EMPTY_IDX = '1;
  localparam logic [ITER_BITS-1:0] ITER_CAP  = ITER_BITS'(MAX_ITER);
  // 4.0 expressed at product scale (2*FRAC_BITS fractional bits)
  localparam logic signed [PROD_W:0] MAG_LIMIT = (PROD_W + 1)'(4) <<< (2 * FRAC_BITS);

  typedef struct packed {
    logic [IDX_BITS-1:0]   idx;
    logic [COORD_BITS-1:0] x0;
    logic [COORD_BITS-1:0] y0;
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic [ITER_BITS-1:0]  iter;
    logic                  escaped;
  } slot_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_CAPT
  } fetch_state_t;

  fetch_state_t fetch_state, fetch_next;

  logic                  pf_valid;
  logic [IDX_BITS-1:0]   pf_idx;
  logic [COORD_BITS-1:0] pf_x0;
  logic [COORD_BITS-1:0] pf_y0;

  slot_t ring [STAGES];
  slot_t tail;
  slot_t empty_slot;
  slot_t step_in;
  slot_t step_out;
  slot_t stage0_next;

  logic tail_valid;
  logic tail_finished;
  logic ram_we;
  logic recirc;
  logic insert;

  logic signed [COORD_BITS-1:0] xs;
  logic signed [COORD_BITS-1:0] ys;
  logic signed [PROD_W-1:0]     xx;
  logic signed [PROD_W-1:0]     yy;
  logic signed [PROD_W-1:0]     xy;
  logic signed [PROD_W:0]       mag;

  logic [ITER_BITS-1:0] iter_ram [RAM_DEPTH];

  // Fetch sequencer: one outstanding pop, data captured the cycle after the strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_state <= FETCH_IDLE;
      rtc_read    <= 1'b0;
    end else begin
      fetch_state <= fetch_next;
      rtc_read    <= (fetch_next == FETCH_REQ);
    end
  end

  always_comb begin
    fetch_next = fetch_state;
    case (fetch_state)
      FETCH_IDLE: if (rtc_poll_ready && !pf_valid) fetch_next = FETCH_REQ;
      FETCH_REQ:  fetch_next = FETCH_CAPT;
      FETCH_CAPT: fetch_next = FETCH_IDLE;
      default:    fetch_next = FETCH_IDLE;
    endcase
  end

  // Prefetch buffer; an all-ones index is dropped at capture
  always_ff @(posedge clock) begin
    if (reset) begin
      pf_valid <= 1'b0;
      pf_idx   <= EMPTY_IDX;
      pf_x0    <= '0;
      pf_y0    <= '0;
    end else if (fetch_state == FETCH_CAPT) begin
      pf_valid <= (idx_from_rtc != EMPTY_IDX);
      pf_idx   <= idx_from_rtc;
      pf_x0    <= x0_from_rtc;
      pf_y0    <= y0_from_rtc;
    end else if (insert) begin
      pf_valid <= 1'b0;
    end
  end

  // Tail decision: retire, recirculate, or refill from the prefetch buffer
  always_comb begin
    empty_slot     = '0;
    empty_slot.idx = EMPTY_IDX;
    tail           = ring[STAGES-1];
    tail_valid     = (tail.idx != EMPTY_IDX);
    tail_finished  = tail.escaped || (tail.iter == ITER_CAP);
    ram_we         = tail_valid && tail_finished && !reset;
    recirc         = tail_valid && !tail_finished;
    insert         = !recirc && pf_valid;
    step_in        = empty_slot;
    if (recirc) begin
      step_in = tail;
    end else if (insert) begin
      step_in.idx = pf_idx;
      step_in.x0  = pf_x0;
      step_in.y0  = pf_y0;
    end
  end

  // Step unit: one z = z^2 + c iteration, or flag escape when |z|^2 > 4
  always_comb begin
    xs       = $signed(step_in.x);
    ys       = $signed(step_in.y);
    xx       = PROD_W'(xs) * PROD_W'(xs);
    yy       = PROD_W'(ys) * PROD_W'(ys);
    xy       = PROD_W'(xs) * PROD_W'(ys);
    mag      = (PROD_W + 1)'(xx) + (PROD_W + 1)'(yy);
    step_out = step_in;
    if (mag > MAG_LIMIT) begin
      step_out.escaped = 1'b1;
    end else begin
      step_out.x    = COORD_BITS'(xx >>> FRAC_BITS) - COORD_BITS'(yy >>> FRAC_BITS) + step_in.x0;
      step_out.y    = COORD_BITS'(xy >>> (FRAC_BITS - 1)) + step_in.y0;
      step_out.iter = step_in.iter + ITER_BITS'(1);
    end
    stage0_next = (recirc || insert) ? step_out : empty_slot;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ring[i] <= empty_slot;
    end else begin
      ring[0] <= stage0_next;
      for (int i = 1; i < STAGES; i++) ring[i] <= ring[i-1];
    end
  end

  // Iteration RAM: contents survive reset; read returns pre-write data
  always_ff @(posedge clock) begin
    if (ram_we) iter_ram[tail.idx] <= tail.iter;
  end

  always_ff @(posedge clock) begin
    if (reset) iter_out <= '0;
    else       iter_out <= iter_ram[iter_idx_in];
  end

`ifdef CELL_WORKER_DONE_PORT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      done_valid   <= 1'b0;
      done_idx     <= '0;
      done_iter    <= '0;
      done_escaped <= 1'b0;
    end else begin
      done_valid   <= ram_we;
      done_idx     <= tail.idx;
      done_iter    <= tail.iter;
      done_escaped <= tail.escaped;
    end
  end
`endif

endmodule

// File: tb/tb_mandel_cell_worker.sv
// Directed bench for mandel_cell_worker: an 8-deep upstream queue model feeds cells and
// results are read back through the iteration RAM read port.
module tb_mandel_cell_worker;

  localparam logic [63:0] FP_ZERO  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] FP_ONE   = 64'h0400_0000_0000_0000;
  localparam logic [63:0] FP_TWO   = 64'h0800_0000_0000_0000;
  localparam logic [63:0] FP_M_TWO = 64'hF800_0000_0000_0000;
  localparam logic [63:0] FP_0P4   = 64'h0199_9999_9999_9999;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rtc_poll_ready;
  logic        rtc_read;
  logic [16:0] idx_from_rtc = '0;
  logic [63:0] x0_from_rtc  = '0;
  logic [63:0] y0_from_rtc  = '0;
  logic [16:0] iter_idx_in  = '0;
  logic [7:0]  iter_out;
`ifdef CELL_WORKER_DONE_PORT_EN
  logic        done_valid;
  logic [16:0] done_idx;
  logic [7:0]  done_iter;
  logic        done_escaped;
`endif

  int tests = 0;
  int fails = 0;

  logic [16:0] q_idx [8];
  logic [63:0] q_x0  [8];
  logic [63:0] q_y0  [8];
  int wr_cnt    = 0;
  int rd_cnt    = 0;
  int reads     = 0;
  int bad_reads = 0;

  always #5 clock = ~clock;

  mandel_cell_worker dut (
    .clock          (clock),
    .reset          (reset),
    .rtc_poll_ready (rtc_poll_ready),
    .rtc_read       (rtc_read),
    .idx_from_rtc   (idx_from_rtc),
    .x0_from_rtc    (x0_from_rtc),
    .y0_from_rtc    (y0_from_rtc),
    .iter_idx_in    (iter_idx_in),
    .iter_out       (iter_out)
`ifdef CELL_WORKER_DONE_PORT_EN
    ,
    .done_valid     (done_valid),
    .done_idx       (done_idx),
    .done_iter      (done_iter),
    .done_escaped   (done_escaped)
`endif
  );

  assign rtc_poll_ready = (wr_cnt != rd_cnt);

  // Upstream queue: pop on rtc_read, data presented the following cycle
  always @(posedge clock) begin
    if (rtc_read) begin
      reads <= reads + 1;
      if (!rtc_poll_ready) begin
        bad_reads <= bad_reads + 1;
      end else begin
        idx_from_rtc <= q_idx[rd_cnt % 8];
        x0_from_rtc  <= q_x0[rd_cnt % 8];
        y0_from_rtc  <= q_y0[rd_cnt % 8];
        rd_cnt       <= rd_cnt + 1;
      end
    end
  end

  task automatic push(input logic [16:0] idx, input logic [63:0] x0, input logic [63:0] y0);
    q_idx[wr_cnt % 8] = idx;
    q_x0[wr_cnt % 8]  = x0;
    q_y0[wr_cnt % 8]  = y0;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic read_iter(input logic [16:0] addr, output logic [7:0] val);
    @(negedge clock);
    iter_idx_in = addr;
    @(posedge clock);
    #1 val = iter_out;
  endtask

  task automatic check_iter(input string name, input logic [16:0] addr, input logic [7:0] exp);
    logic [7:0] got;
    read_iter(addr, got);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: iter_out=0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (rtc_read !== 1'b0) begin
      fails++;
      $display("FAIL reset_rtc_read: got %b expected 0", rtc_read);
    end
    tests++;
    if (iter_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_iter_out: got 0x%02h expected 0x00", iter_out);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_origin();
    @(negedge clock);
    push(17'h0DEAD, FP_ZERO, FP_ZERO);
    repeat (1200) @(posedge clock);
    check_iter("origin_max_iter", 17'h0DEAD, 8'hFF);
  endtask

  task automatic test_escape_fast();
    logic [7:0] got;
    @(negedge clock);
    push(17'h0BEEF, FP_M_TWO, FP_ONE);
    repeat (60) @(posedge clock);
    read_iter(17'h0DEAD, got);
    // Address change must not show up until the next clock edge
    @(negedge clock);
    iter_idx_in = 17'h0BEEF;
    #1;
    tests++;
    if (iter_out !== 8'hFF) begin
      fails++;
      $display("FAIL read_latency_hold: iter_out=0x%02h expected 0xff", iter_out);
    end
    @(posedge clock);
    #1;
    tests++;
    if (iter_out !== 8'h01) begin
      fails++;
      $display("FAIL escape_iter1: iter_out=0x%02h expected 0x01", iter_out);
    end
  endtask

  task automatic test_escape_seven();
    @(negedge clock);
    push(17'h01337, FP_0P4, FP_ZERO);
    repeat (80) @(posedge clock);
    check_iter("escape_iter7", 17'h01337, 8'h07);
  endtask

  task automatic test_back_to_back();
    int reads_before;
    reads_before = reads;
    @(negedge clock);
    push(17'h00100, FP_ZERO, FP_ZERO);
    push(17'h00101, FP_M_TWO, FP_ONE);
    push(17'h00102, FP_0P4, FP_ZERO);
    repeat (1300) @(posedge clock);
    check_iter("b2b_origin", 17'h00100, 8'hFF);
    check_iter("b2b_iter1", 17'h00101, 8'h01);
    check_iter("b2b_iter7", 17'h00102, 8'h07);
    tests++;
    if (bad_reads !== 0) begin
      fails++;
      $display("FAIL read_while_empty: count=%0d expected 0", bad_reads);
    end
    tests++;
    if ((reads - reads_before) !== 3 || rd_cnt !== wr_cnt) begin
      fails++;
      $display("FAIL b2b_pops: pops=%0d expected 3, queue left=%0d expected 0",
               reads - reads_before, wr_cnt - rd_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    push(17'h0DEAD, FP_M_TWO, FP_ONE);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clock);
      #1;
      if (rtc_read) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL midflight_fetch: rtc_read seen=%b expected 1", seen);
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (rtc_read !== 1'b0) begin
      fails++;
      $display("FAIL midflight_reset_read: got %b expected 0", rtc_read);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    check_iter("midflight_dropped", 17'h0DEAD, 8'hFF);
    check_iter("midflight_kept", 17'h0BEEF, 8'h01);
  endtask

  task automatic test_boundary();
    @(negedge clock);
    push(17'h1FFFF, FP_0P4, FP_ZERO);
    push(17'h00200, FP_TWO, FP_ZERO);
    repeat (80) @(posedge clock);
    check_iter("boundary_mag4", 17'h00200, 8'h02);
    tests++;
    if (rd_cnt !== wr_cnt) begin
      fails++;
      $display("FAIL boundary_queue_drain: left=%0d expected 0", wr_cnt - rd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_origin();
    test_escape_fast();
    test_escape_seven();
    test_back_to_back();
    test_reset_midflight();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
